// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//   Forwarding and hazard unit that sits beside decode in the Buraq-mini
//   RV32IM pipeline. It produces a 4-bit operand-select code for each decode
//   source operand. Load-use and MUL/DIV dependences become decode stalls
//   rather than forward codes. A per-register scoreboard tracks results that
//   are still being computed in the multi-cycle unit. When that unit finishes,
//   its result is bypassed to decode in the same cycle.
//
//   Select codes: 1000 EX ALU, 0010 MEM ALU, 0100 MEM load, 0001 WB,
//                 0101 long-op completion bypass, 0000 register file.
//
//   Parameters: NumReadPorts (1..4), RegAddrWidth (register 0 reads as zero)
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     rs_addr_i / rs_valid_i   decode source addresses / read enables
//     {ex,mem,wb}_we_i/_rd_i   stage write enable / destination
//     ex_load_i, mem_load_i    stage holds a load
//     ex_long_i                EX holds a MUL/DIV that has not issued yet
//     lo_issue_i/_rd_i         long op enters the multi-cycle unit
//     lo_done_i/_rd_i          multi-cycle unit returns its result
//     operand_ctrl_o           per-port select code, port p at [p*4 +: 4]
//     stall_o                  hold PC and IF/ID, inject a bubble into EX
//     lo_busy_o                at least one scoreboard bit is set
//     stall_cnt_o              stall-cycle counter, saturating
//                              (present only with HAZARD_PERF_CNT_EN)
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
// ---------------------------------------------------------------------------

// Per-operand forward select and stall detection
module hfu_port #(
  parameter int RegAddrWidth = 5
) (
  input  logic [RegAddrWidth-1:0]      rs_i,
  input  logic                         valid_i,
  input  logic                         ex_we_i,
  input  logic [RegAddrWidth-1:0]      ex_rd_i,
  input  logic                         ex_load_i,
  input  logic                         ex_long_i,
  input  logic                         mem_we_i,
  input  logic [RegAddrWidth-1:0]      mem_rd_i,
  input  logic                         mem_load_i,
  input  logic                         wb_we_i,
  input  logic [RegAddrWidth-1:0]      wb_rd_i,
  input  logic                         lo_done_i,
  input  logic [RegAddrWidth-1:0]      lo_done_rd_i,
  input  logic [2**RegAddrWidth-1:0]   busy_i,
  output logic [3:0]                   code_o,
  output logic                         stall_o
);
  logic w_rd, w_ex, w_mem, w_wb, w_lo;

  // An operand with address x0 never matches, so it always reads zero
  // from the register file.
  assign w_rd  = valid_i && (rs_i != '0);
  assign w_ex  = w_rd && ex_we_i  && (ex_rd_i  == rs_i);
  assign w_mem = w_rd && mem_we_i && (mem_rd_i == rs_i);
  assign w_wb  = w_rd && wb_we_i  && (wb_rd_i  == rs_i);
  assign w_lo  = w_rd && lo_done_i && (lo_done_rd_i == rs_i);

  always_comb begin
    code_o  = 4'b0000;
    stall_o = 1'b0;
    if (w_ex) begin
      // A load or MUL/DIV result in EX is not ready yet, so stall and
      // emit the register-file code instead of a forward.
      if (ex_load_i || ex_long_i) stall_o = 1'b1;
      else                        code_o  = 4'b1000;
    end else if (w_mem) begin
      code_o = mem_load_i ? 4'b0100 : 4'b0010;
    end else if (w_wb) begin
      code_o = 4'b0001;
    end else if (w_lo) begin
      code_o = 4'b0101;
    end else if (w_rd && busy_i[rs_i]) begin
      // Reached only when no newer in-flight producer forwards this
      // register and the multi-cycle unit has not delivered it.
      stall_o = 1'b1;
    end
  end
endmodule

module hazard_forward_unit #(
  parameter int NumReadPorts = 2,
  parameter int RegAddrWidth = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NumReadPorts*RegAddrWidth-1:0] rs_addr_i,
  input  logic [NumReadPorts-1:0]              rs_valid_i,
  input  logic                                 ex_we_i,
  input  logic                                 mem_we_i,
  input  logic                                 wb_we_i,
  input  logic [RegAddrWidth-1:0]              ex_rd_i,
  input  logic [RegAddrWidth-1:0]              mem_rd_i,
  input  logic [RegAddrWidth-1:0]              wb_rd_i,
  input  logic                                 ex_load_i,
  input  logic                                 mem_load_i,
  input  logic                                 ex_long_i,
  input  logic                                 lo_issue_i,
  input  logic [RegAddrWidth-1:0]              lo_issue_rd_i,
  input  logic                                 lo_done_i,
  input  logic [RegAddrWidth-1:0]              lo_done_rd_i,
  output logic [NumReadPorts*4-1:0]            operand_ctrl_o,
  output logic                                 stall_o,
  output logic                                 lo_busy_o
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [31:0]                         stall_cnt_o
`endif
);
  localparam int NumRegs = 2**RegAddrWidth;

  logic [NumRegs-1:0]      r_busy;
  logic [NumReadPorts-1:0] w_port_stall;
  logic                    w_waw;

  // Scoreboard. When the same register issues and completes in one cycle,
  // the issue belongs to a newer op, so the later set must win. x0 is never
  // marked busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (lo_done_i)                          r_busy[lo_done_rd_i]  <= 1'b0;
      if (lo_issue_i && lo_issue_rd_i != '0)  r_busy[lo_issue_rd_i] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_port
    hfu_port #(.RegAddrWidth(RegAddrWidth)) u_port (
      .rs_i         (rs_addr_i[p*RegAddrWidth +: RegAddrWidth]),
      .valid_i      (rs_valid_i[p]),
      .ex_we_i      (ex_we_i),
      .ex_rd_i      (ex_rd_i),
      .ex_load_i    (ex_load_i),
      .ex_long_i    (ex_long_i),
      .mem_we_i     (mem_we_i),
      .mem_rd_i     (mem_rd_i),
      .mem_load_i   (mem_load_i),
      .wb_we_i      (wb_we_i),
      .wb_rd_i      (wb_rd_i),
      .lo_done_i    (lo_done_i),
      .lo_done_rd_i (lo_done_rd_i),
      .busy_i       (r_busy),
      .code_o       (operand_ctrl_o[p*4 +: 4]),
      .stall_o      (w_port_stall[p])
    );
  end

  // WAW: an EX write to a register that the multi-cycle unit still owns
  // would be overwritten later by the long result. A same-cycle completion
  // on that register releases it.
  assign w_waw = ex_we_i && (ex_rd_i != '0) && r_busy[ex_rd_i] &&
                 !(lo_done_i && (lo_done_rd_i == ex_rd_i));

  assign stall_o   = (|w_port_stall) | w_waw;
  assign lo_busy_o = |r_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (stall_o && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rs_addr;
  logic [1:0]  rs_valid;
  logic        ex_we, mem_we, wb_we, ex_load, mem_load, ex_long;
  logic [4:0]  ex_rd, mem_rd, wb_rd, lo_issue_rd, lo_done_rd;
  logic        lo_issue, lo_done;
  logic [7:0]  operand_ctrl;
  logic        stall, lo_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_forward_unit #(.NumReadPorts(2), .RegAddrWidth(5)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr), .rs_valid_i(rs_valid),
    .ex_we_i(ex_we), .mem_we_i(mem_we), .wb_we_i(wb_we),
    .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .wb_rd_i(wb_rd),
    .ex_load_i(ex_load), .mem_load_i(mem_load), .ex_long_i(ex_long),
    .lo_issue_i(lo_issue), .lo_issue_rd_i(lo_issue_rd),
    .lo_done_i(lo_done), .lo_done_rd_i(lo_done_rd),
    .operand_ctrl_o(operand_ctrl), .stall_o(stall), .lo_busy_o(lo_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,.stall_cnt_o(stall_cnt)
`endif
  );

  // Observed vector: {port1 code, port0 code, stall, lo_busy}
  logic [9:0] obs;
  assign obs = {operand_ctrl, stall, lo_busy};

  typedef struct { string name; logic [9:0] v; } exp_t;
  exp_t q[$];
  int n_run = 0, n_fail = 0;

  task automatic idle();
    rs_addr = '0; rs_valid = '0;
    ex_we = 0; mem_we = 0; wb_we = 0; ex_load = 0; mem_load = 0; ex_long = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0;
    lo_issue = 0; lo_issue_rd = 0; lo_done = 0; lo_done_rd = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] v);
    rs_addr = {a1, a0}; rs_valid = v;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; idle(); #1;
    q.push_back('{name:"reset", v:10'b0000_0000_0_0});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
`ifdef HAZARD_PERF_CNT_EN
    n_run++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
`endif
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_ex_fwd();
    exp_t e;
    idle(); ex_we = 1; ex_rd = 5; set_rs(5, 5, 2'b11);
    q.push_back('{name:"ex_fwd_both", v:10'b1000_1000_0_0});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    cyc(); set_rs(0, 0, 2'b11); ex_rd = 0;
    q.push_back('{name:"ex_fwd_x0", v:10'b0000_0000_0_0});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    cyc(); ex_rd = 5; set_rs(5, 5, 2'b00);
    q.push_back('{name:"ex_fwd_novalid", v:10'b0000_0000_0_0});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    cyc();
  endtask

  task automatic test_load_use();
    exp_t e;
    idle(); ex_we = 1; ex_rd = 7; ex_load = 1; set_rs(0, 7, 2'b10);
    q.push_back('{name:"load_use_stall", v:10'b0000_0000_1_0});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    cyc(); idle(); mem_we = 1; mem_rd = 7; mem_load = 1; set_rs(0, 7, 2'b10);
    q.push_back('{name:"load_use_mem", v:10'b0100_0000_0_0});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    cyc();
  endtask

  task automatic test_priority();
    exp_t e;
    logic [9:0] exp_v [3];
    exp_v[0] = 10'b0000_1000_0_0;
    exp_v[1] = 10'b0000_0010_0_0;
    exp_v[2] = 10'b0000_0001_0_0;
    idle(); ex_we = 1; mem_we = 1; wb_we = 1; ex_rd = 3; mem_rd = 3; wb_rd = 3;
    set_rs(3, 0, 2'b01);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) ex_we = 0;
      if (k == 2) mem_we = 0;
      q.push_back('{name:$sformatf("priority_%0d", k), v:exp_v[k]});
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
      cyc();
    end
  endtask

  task automatic test_long_op();
    exp_t e;
    // cycle 0: MUL in EX writing x9 issues; dependent op in decode
    idle(); ex_we = 1; ex_rd = 9; ex_long = 1; lo_issue = 1; lo_issue_rd = 9;
    set_rs(9, 0, 2'b01);
    q.push_back('{name:"long_c0", v:10'b0000_0000_1_0});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    for (int c = 1; c <= 9; c++) begin
      cyc(); idle();
      if (c == 5) begin ex_we = 1; ex_rd = 9; end  // WAW on busy x9
      else set_rs(9, 0, 2'b01);
      q.push_back('{name:$sformatf("long_c%0d", c), v:10'b0000_0000_1_1});
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    end
    cyc(); idle(); lo_done = 1; lo_done_rd = 9; set_rs(9, 0, 2'b01);
    q.push_back('{name:"long_c10_bypass", v:10'b0000_0101_0_1});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    cyc(); idle(); set_rs(9, 0, 2'b01);
    q.push_back('{name:"long_c11_clear", v:10'b0000_0000_0_0});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    cyc();
  endtask

  task automatic test_set_wins();
    exp_t e;
    logic [9:0] exp_v [7];
    exp_v[0] = 10'b0000_0000_0_0;  // issue x9
    exp_v[1] = 10'b0000_0000_0_1;  // done x9 + issue x9 together
    exp_v[2] = 10'b0000_0000_1_1;  // x9 still busy: stall
    exp_v[3] = 10'b0000_0101_0_1;  // final completion bypass
    exp_v[4] = 10'b0000_0000_0_0;  // released
    exp_v[5] = 10'b0000_0101_0_0;  // done on non-busy x12: bypass only
    exp_v[6] = 10'b0000_0000_0_0;  // no scoreboard change
    for (int k = 0; k < 7; k++) begin
      idle();
      case (k)
        0: begin lo_issue = 1; lo_issue_rd = 9; end
        1: begin lo_issue = 1; lo_issue_rd = 9; lo_done = 1; lo_done_rd = 9; end
        2: set_rs(9, 0, 2'b01);
        3: begin lo_done = 1; lo_done_rd = 9; set_rs(9, 0, 2'b01); end
        4: set_rs(9, 0, 2'b01);
        5: begin lo_done = 1; lo_done_rd = 12; set_rs(12, 0, 2'b01); end
        default: set_rs(12, 0, 2'b01);
      endcase
      q.push_back('{name:$sformatf("set_wins_%0d", k), v:exp_v[k]});
      @(negedge clk); e = q.pop_front(); n_run++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    idle(); lo_issue = 1; lo_issue_rd = 4;
    cyc(); idle();
    q.push_back('{name:"mid_busy", v:10'b0000_0000_0_1});
    @(negedge clk); e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
    #1 rst_n = 1'b0;
    q.push_back('{name:"mid_reset", v:10'b0000_0000_0_0});
    #1 e = q.pop_front(); n_run++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got=%b exp=%b", e.name, obs, e.v); end
`ifdef HAZARD_PERF_CNT_EN
    n_run++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_reset_cnt got=%0d exp=0", stall_cnt); end
`endif
    @(negedge clk); rst_n = 1'b1;
    cyc();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    // three load-use stall cycles, then idle
    idle(); ex_we = 1; ex_rd = 7; ex_load = 1; set_rs(7, 0, 2'b01);
    repeat (3) cyc();
    idle();
    @(negedge clk); n_run++;
    if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_cnt got=%0d exp=3", stall_cnt); end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_ex_fwd();
    test_load_use();
    test_priority();
    test_long_op();
    test_set_wins();
    test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    if (q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard unit for the Buraq-mini RV32IM pipeline, sitting beside the decode stage. It generates per-read-port operand-select codes for N decode source operands and converts load-use and long-latency (MUL/DIV) dependences into decode stalls instead of invalid forward codes. A register scoreboard tracks outstanding multi-cycle results, and a bypass forwards the completing result in its completion cycle.

## Interface
- NumReadPorts, 2: decode source operands checked (1..4)
- RegAddrWidth, 5: register address width; register 0 is hard-wired zero
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs_addr_i  in  NumReadPorts*RegAddrWidth  decode source addresses, port p at [p*RegAddrWidth +: RegAddrWidth]
- rs_valid_i  in  NumReadPorts  port p actually reads its register
- ex_we_i, mem_we_i, wb_we_i  in  1 each  stage writes the register file
- ex_rd_i, mem_rd_i, wb_rd_i  in  RegAddrWidth each  stage destination
- ex_load_i, mem_load_i  in  1 each  stage holds a load
- ex_long_i  in  1  EX holds a MUL/DIV not yet issued
- lo_issue_i  in  1  long op leaves EX into the multi-cycle unit this cycle
- lo_issue_rd_i  in  RegAddrWidth  its destination
- lo_done_i  in  1  multi-cycle unit presents its result this cycle
- lo_done_rd_i  in  RegAddrWidth  destination of that result
- operand_ctrl_o  out  NumReadPorts*4  per-port select code, port p at [p*4 +: 4]
- stall_o  out  1  hold PC and IF/ID, inject bubble into EX
- lo_busy_o  out  1  at least one scoreboard bit set

## Operation
- Per port p, match means rs_valid_i[p], rs != 0, stage we set, rd == rs. Priority EX > MEM > WB > long-op completion > register file.
- Codes: EX ALU 4'b1000; MEM ALU 4'b0010; MEM load 4'b0100; WB 4'b0001; long-op bypass 4'b0101 (lo_done_i, lo_done_rd_i == rs); register file 4'b0000.
- EX match with ex_load_i or ex_long_i: stall_o=1, code 4'b0000 (code 4'b0011 is never produced).
- Scoreboard busy[2**RegAddrWidth-1:0]; bit 0 never set.
- Per port, busy[rs] and no higher-priority stage match and not bypassed by lo_done: stall_o=1.
- WAW: ex_we_i with busy[ex_rd_i] and ex_rd_i != 0, and no same-cycle lo_done on that rd: stall_o=1.
- Update on clk: lo_issue_i sets busy[lo_issue_rd_i]; lo_done_i clears busy[lo_done_rd_i]; same rd both events: set wins.
- lo_done_i on a non-busy register: ignored, no error.
- Pipeline flush does not touch the scoreboard; the multi-cycle unit completes and clears normally.

## Timing
- operand_ctrl_o and stall_o combinational, same cycle as inputs; no input-to-output register.
- Scoreboard set/clear visible from the cycle after the edge; lo_done bypass covers the completion cycle itself.
- Load-use costs exactly one stall cycle: next cycle the load is in MEM and the code is 4'b0100.
- Long-op dependence stalls from issue until the lo_done_i cycle inclusive-exclusive: stall drops in the lo_done_i cycle, code 4'b0101.
- Reset (async assert, sync-released): busy all 0, lo_busy_o=0, counter 0. Reset mid long op clears pending bits; the multi-cycle unit is reset by the same rst_n.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds output stall_cnt_o [31:0], increments every cycle stall_o=1, saturates at 32'hFFFF_FFFF, reset to 0.
- Not defined: no port, no counter logic.

## Test plan
- EX ALU rd=5, rs0=5, rs1=5 -> both codes 4'b1000, stall_o=0; same with rs=0 -> 4'b0000.
- EX load rd=7, rs1=7 -> stall_o=1 one cycle; next cycle load in MEM -> code 4'b0100, stall_o=0.
- EX rd=3, MEM rd=3, WB rd=3 all writing, rs0=3 -> 4'b1000; drop ex_we_i -> 4'b0010; drop mem_we_i -> 4'b0001.
- lo_issue rd=9; 10 cycles later lo_done rd=9; rs0=9 throughout -> stall_o=1 cycles 1..9, cycle 10 code 4'b0101 stall_o=0, lo_busy_o=0 after.
- Same-cycle lo_done rd=9 and lo_issue rd=9 -> busy[9] stays 1; rs0=9 next cycle stalls.
- rst_n low with busy[4]=1 mid-operation -> lo_busy_o=0 immediately; with HAZARD_PERF_CNT_EN, stall_cnt_o=0.
